// File: rtl/moving_average_filter_if.sv
// Sample stream bundle for the moving-average filter.
// Handshake: sample_valid is a one-cycle strobe with no back-pressure; every
// strobe not masked by flush or reset is accepted, and out_valid pulses for
// exactly one cycle, one clock later, with sample_out holding the new average.
interface moving_average_filter_if #(
    parameter int WIDTH = 24
);
    logic                    sample_valid;
    logic signed [WIDTH-1:0] sample_in;
    logic                    flush;
    logic signed [WIDTH-1:0] sample_out;
    logic                    out_valid;
    logic                    primed;

    // Producer side: presents samples and flush, observes the average.
    modport master (
        output sample_valid,
        output sample_in,
        output flush,
        input  sample_out,
        input  out_valid,
        input  primed
    );

    // Filter side.
    modport slave (
        input  sample_valid,
        input  sample_in,
        input  flush,
        output sample_out,
        output out_valid,
        output primed
    );
endinterface

// File: rtl/moving_average_filter.sv
// Running average over the last N samples. Each sample is pre-scaled by 1/N
// (arithmetic shift) on entry, so the accumulator directly holds the average.
// A circular buffer remembers the scaled samples so the oldest one can be
// subtracted once the window is full. During fill the output is the partial
// sum, deliberately not normalised to the current occupancy.
module moving_average_filter #(
    parameter int N        = 32,
    parameter int EXPONENT = 5,
    parameter int WIDTH    = 24
) (
    input  logic                clk,
    input  logic                reset,
    moving_average_filter_if.slave bus,
    output logic [EXPONENT-1:0] o_dbg_rd_ptr,
    output logic [EXPONENT-1:0] o_dbg_wr_ptr,
    output logic [EXPONENT:0]   o_dbg_count
);
    localparam logic [EXPONENT:0]   LP_FULL = (EXPONENT + 1)'(N);
    localparam logic [EXPONENT-1:0] LP_ONE  = EXPONENT'(1);

    // Window storage; never reset, entries are only read once rewritten.
    logic signed [WIDTH-1:0] r_mem [0:N-1];

    logic [EXPONENT-1:0]     r_rd_ptr;
    logic [EXPONENT-1:0]     r_wr_ptr;
    logic [EXPONENT:0]       r_count;
    logic signed [WIDTH-1:0] r_acc;
    logic signed [WIDTH-1:0] r_sample_out;
    logic                    r_out_valid;
    logic                    r_primed;

    logic signed [WIDTH-1:0] w_scaled;
    logic signed [WIDTH-1:0] w_oldest;
    logic                    w_full;
    logic                    w_wr_en;
    logic [EXPONENT-1:0]     w_rd_ptr_nxt;
    logic [EXPONENT-1:0]     w_wr_ptr_nxt;
    logic [EXPONENT:0]       w_count_nxt;
    logic signed [WIDTH-1:0] w_acc_nxt;
    logic signed [WIDTH-1:0] w_sample_out_nxt;
    logic                    w_out_valid_nxt;
    logic                    w_primed_nxt;

    // Floor division by N: arithmetic shift rounds toward minus infinity.
    assign w_scaled = bus.sample_in >>> EXPONENT;
    // Combinational read returns the pre-write contents: read-before-write.
    assign w_oldest = r_mem[r_rd_ptr];
    assign w_full   = (r_count == LP_FULL);

    // Next-state computation: flush clears, a strobe updates, otherwise hold.
    always_comb begin
        w_wr_en          = 1'b0;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_count_nxt      = r_count;
        w_acc_nxt        = r_acc;
        w_sample_out_nxt = r_sample_out;
        w_out_valid_nxt  = 1'b0;
        w_primed_nxt     = r_primed;
        if (bus.flush) begin
            w_rd_ptr_nxt     = '0;
            w_wr_ptr_nxt     = '0;
            w_count_nxt      = '0;
            w_acc_nxt        = '0;
            w_sample_out_nxt = '0;
            w_primed_nxt     = 1'b0;
        end else if (bus.sample_valid) begin
            w_wr_en         = 1'b1;
            w_wr_ptr_nxt    = r_wr_ptr + LP_ONE;
            w_out_valid_nxt = 1'b1;
            if (w_full) begin
                // Steady: rd_ptr tracks wr_ptr, oldest leaves as newest enters.
                w_rd_ptr_nxt = r_rd_ptr + LP_ONE;
                w_acc_nxt    = r_acc + w_scaled - w_oldest;
            end else begin
                w_count_nxt  = r_count + 1'b1;
                w_acc_nxt    = r_acc + w_scaled;
            end
            w_sample_out_nxt = w_acc_nxt;
            w_primed_nxt     = (w_count_nxt == LP_FULL);
        end
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_acc        <= '0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
            r_primed     <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_count      <= w_count_nxt;
            r_acc        <= w_acc_nxt;
            r_sample_out <= w_sample_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_primed     <= w_primed_nxt;
        end
    end

    // Buffer write; a sample arriving with reset is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr] <= w_scaled;
        end
    end

    assign bus.sample_out = r_sample_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.primed     = r_primed;

    assign o_dbg_rd_ptr = r_rd_ptr;
    assign o_dbg_wr_ptr = r_wr_ptr;
    assign o_dbg_count  = r_count;
endmodule
